// File: rtl/sprite_blit_engine_pkg.sv
// Shared types for the sprite blitter: blit modes and FSM states.
package blit_pkg;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'd0,
    MODE_KEYED = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_RSVD  = 2'd3
  } blit_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } blit_state_t;

  // Reserved mode falls back to plain copy, so only FILL and KEYED need decoding.
  function automatic logic mode_is_fill(blit_mode_t m);
    return m == MODE_FILL;
  endfunction

  function automatic logic mode_is_keyed(blit_mode_t m);
    return m == MODE_KEYED;
  endfunction

endpackage

// File: rtl/sprite_blit_engine_if.sv
// SDRAM arbiter port: one request (read or write) held until valid.
interface sprite_blit_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 25
);
  logic              read_req;
  logic              write_req;
  logic              valid;
  logic [ADDR_W-1:0] address_to_sdram;
  logic [DATA_W-1:0] data_from_sdram;
  logic [DATA_W-1:0] data_out;

  modport master (
    output read_req, write_req, address_to_sdram, data_out,
    input  valid, data_from_sdram
  );

  modport slave (
    input  read_req, write_req, address_to_sdram, data_out,
    output valid, data_from_sdram
  );
endinterface

// File: rtl/sprite_blit_engine_addr_gen.sv
// Source/destination address and visibility for the current (x,y) pixel.
module blit_addr_gen #(
  parameter int              ADDR_W  = 25,
  parameter int              DIM_W   = 10,
  parameter logic [ADDR_W-1:0] FB_BASE = '0,
  parameter int              FB_W    = 640,
  parameter int              FB_H    = 480
) (
  input  logic              hflip,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [DIM_W-1:0]  dst_x,
  input  logic [DIM_W-1:0]  dst_y,
  input  logic [DIM_W-1:0]  dimx,
  input  logic [DIM_W-1:0]  x,
  input  logic [DIM_W-1:0]  y,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              visible
);
  logic [DIM_W-1:0] sx;
  logic [DIM_W:0]   px;
  logic [DIM_W:0]   py;

  // One extra bit on the screen coordinates keeps dst+offset from wrapping back on screen.
  always_comb begin
    sx       = hflip ? (dimx - DIM_W'(1) - x) : x;
    px       = {1'b0, dst_x} + {1'b0, x};
    py       = {1'b0, dst_y} + {1'b0, y};
    visible  = (px < (DIM_W+1)'(FB_W)) && (py < (DIM_W+1)'(FB_H));
    src_addr = src_base + ADDR_W'(y) * ADDR_W'(dimx) + ADDR_W'(sx);
    dst_addr = FB_BASE + ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);
  end
endmodule

// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks a DIMX x DIMY sprite pixel by pixel, one SDRAM access at a time.
module sprite_blit_engine
  import blit_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 25,
  parameter int                DIM_W   = 10,
  parameter logic [ADDR_W-1:0] FB_BASE = '0,
  parameter int                FB_W    = 640,
  parameter int                FB_H    = 480
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  blit_mode_t           mode,
  input  logic                 hflip,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [DIM_W-1:0]     dst_x,
  input  logic [DIM_W-1:0]     dst_y,
  input  logic [DIM_W-1:0]     dimx,
  input  logic [DIM_W-1:0]     dimy,
  input  logic [DATA_W-1:0]    key_color,
  sprite_blit_engine_if.master sdram,
  output logic                 busy,
  output logic                 done
);
  blit_state_t       state_q;
  blit_mode_t        mode_q;
  logic              hflip_q;
  logic [ADDR_W-1:0] src_q;
  logic [DIM_W-1:0]  dstx_q, dsty_q, dimx_q, dimy_q;
  logic [DATA_W-1:0] key_q, pix_q;
  logic [DIM_W-1:0]  x_q, y_q, x_d, y_d;
  logic              last_px, adv, key_hit;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              visible;

  blit_addr_gen #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .FB_BASE(FB_BASE), .FB_W(FB_W), .FB_H(FB_H)
  ) u_addr (
    .hflip(hflip_q), .src_base(src_q), .dst_x(dstx_q), .dst_y(dsty_q),
    .dimx(dimx_q), .x(x_q), .y(y_q),
    .src_addr(src_addr), .dst_addr(dst_addr), .visible(visible)
  );

  // Raster-order counter step and the conditions that retire the current pixel.
  always_comb begin
    last_px = (x_q == dimx_q - DIM_W'(1)) && (y_q == dimy_q - DIM_W'(1));
    x_d     = x_q + DIM_W'(1);
    y_d     = y_q;
    if (x_q == dimx_q - DIM_W'(1)) begin
      x_d = '0;
      y_d = y_q + DIM_W'(1);
    end
    key_hit = mode_is_keyed(mode_q) && (sdram.data_from_sdram == key_q);
    adv     = ((state_q == ST_CHECK) && !visible) ||
              ((state_q == ST_RD) && sdram.valid && key_hit) ||
              ((state_q == ST_WR) && sdram.valid);
  end

  // Control FSM, command latch, pixel counters and pixel register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      hflip_q <= 1'b0;
      src_q   <= '0;
      dstx_q  <= '0;
      dsty_q  <= '0;
      dimx_q  <= '0;
      dimy_q  <= '0;
      key_q   <= '0;
      pix_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            hflip_q <= hflip;
            src_q   <= src_base;
            dstx_q  <= dst_x;
            dsty_q  <= dst_y;
            dimx_q  <= dimx;
            dimy_q  <= dimy;
            key_q   <= key_color;
            x_q     <= '0;
            y_q     <= '0;
            state_q <= (dimx == '0 || dimy == '0) ? ST_DONE : ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (visible) state_q <= mode_is_fill(mode_q) ? ST_WR : ST_RD;
        end
        ST_RD: begin
          if (sdram.valid) begin
            pix_q <= sdram.data_from_sdram;
            if (!key_hit) state_q <= ST_WR;
          end
        end
        ST_WR:   ;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (adv) begin
        x_q     <= x_d;
        y_q     <= y_d;
        state_q <= last_px ? ST_DONE : ST_CHECK;
      end
    end
  end

  // Bus and status outputs decoded from the state register only.
  always_comb begin
    sdram.read_req         = (state_q == ST_RD);
    sdram.write_req        = (state_q == ST_WR);
    sdram.address_to_sdram = '0;
    sdram.data_out         = '0;
    if (state_q == ST_RD) sdram.address_to_sdram = src_addr;
    if (state_q == ST_WR) begin
      sdram.address_to_sdram = dst_addr;
      sdram.data_out         = mode_is_fill(mode_q) ? key_q : pix_q;
    end
    busy = (state_q == ST_CHECK) || (state_q == ST_RD) || (state_q == ST_WR);
    done = (state_q == ST_DONE);
  end
endmodule
